regfile_wp_arbiter: RTL and testbench

REGFILE_WP_ARBITER -- requirements
Module: regfile_wp_arbiter

---
 rtl/regfile_wp_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wp_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wp_arbiter.sv
// regfile_wp_arbiter
//   Arbitrates two writeback sources onto the single register-file write port.
//   req0 (pipeline) normally wins. req1 (long-latency unit) is force-granted
//   once it has been refused STARVE_LIMIT consecutive cycles. The winning
//   write is registered and presented one cycle after the handshake.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   hold                    blocks all grants while high
//   req0_valid/reg/data     primary writeback request
//   req0_ready              req0 accepted this cycle (combinational)
//   req1_valid/reg/data     secondary writeback request
//   req1_ready              req1 accepted this cycle (combinational)
//   reg_write               register-file write enable (0 for r0 targets)
//   write_reg, write_data   register-file write address / data
//   grant_id                source of the presented write (0 = req0, 1 = req1)
//   starve_cnt              consecutive refusals of req1
module regfile_wp_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hold,
    input  logic        req0_valid,
    input  logic [4:0]  req0_reg,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_reg,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        grant_id,
    output logic [3:0]  starve_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        PRIO0,
        FORCE1
    } state_t;

    state_t      state;
    logic        grant0;
    logic        grant1;
    logic        xfer;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;
    logic [3:0]  cnt_next;

    always_comb begin
        grant1     = req1_valid && ((state == FORCE1) || !req0_valid);
        grant0     = req0_valid && !grant1;
        // Readies are also gated by reset so nothing is accepted in reset.
        req0_ready = reset_n && !hold && grant0;
        req1_ready = reset_n && !hold && grant1;
        xfer       = req0_ready || req1_ready;
        sel_reg    = req1_ready ? req1_reg  : req0_reg;
        sel_data   = req1_ready ? req1_data : req0_data;
        // Refusal streak: only a cycle where req1 waits and loses counts.
        if (req1_valid && !req1_ready)
            cnt_next = (starve_cnt == LIMIT) ? starve_cnt : 4'(starve_cnt + 4'd1);
        else
            cnt_next = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PRIO0;
            starve_cnt <= '0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            grant_id   <= 1'b0;
        end else if (hold) begin
            reg_write <= 1'b0;
        end else begin
            if (xfer) begin
                reg_write  <= (sel_reg != 5'd0);
                write_reg  <= sel_reg;
                write_data <= sel_data;
                grant_id   <= req1_ready;
            end else begin
                reg_write <= 1'b0;
            end
            starve_cnt <= cnt_next;
            case (state)
                PRIO0:   if (cnt_next == LIMIT) state <= FORCE1;
                FORCE1:  if (xfer || !req1_valid) state <= PRIO0;
                default: state <= PRIO0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wp_arbiter.sv
module tb_regfile_wp_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hold;
    logic        req0_valid;
    logic [4:0]  req0_reg;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_reg;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        grant_id;
    logic [3:0]  starve_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: req1 is owed a forced grant when its refusal streak
    // has reached LIMIT.
    int          m_streak;
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic        m_gid;
    logic        e_r0, e_r1;

    regfile_wp_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .grant_id(grant_id), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_streak = 0; m_rw = 1'b0; m_wreg = '0; m_wdata = '0; m_gid = 1'b0;
    endfunction

    function automatic void model_ready();
        logic owed;
        owed = (m_streak >= LIMIT);
        e_r1 = reset_n && !hold && req1_valid && (owed || !req0_valid);
        e_r0 = reset_n && !hold && req0_valid && !e_r1;
    endfunction

    function automatic void model_edge();
        model_ready();
        if (hold) begin
            m_rw = 1'b0;
        end else begin
            if (e_r1) begin
                m_rw = (req1_reg != 0); m_wreg = req1_reg; m_wdata = req1_data; m_gid = 1'b1;
            end else if (e_r0) begin
                m_rw = (req0_reg != 0); m_wreg = req0_reg; m_wdata = req0_data; m_gid = 1'b0;
            end else begin
                m_rw = 1'b0;
            end
            if (req1_valid && !e_r1) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
            else m_streak = 0;
        end
    endfunction

    // Inputs are driven 1 time unit after the rising edge; this updates the
    // model from the current inputs, then moves to 1 unit past the next edge.
    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                         input logic h);
        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
        hold = h;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
        model_reset();
        @(posedge clk); #3;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
        checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL reset_reg_write got=%b exp=0", reg_write); end
        checks++; if ({write_reg, write_data, grant_id, starve_cnt} !== '0) begin failures++; $display("FAIL reset_outputs got=%0h/%0h/%0b/%0d exp=0", write_reg, write_data, grant_id, starve_cnt); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(1'b1, 5'd3, 32'hABCD, 1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL reset_first_accept got=%b exp=1", req0_ready); end
        advance();
        checks++; if ({reg_write, write_reg, write_data} !== {1'b1, 5'd3, 32'hABCD}) begin failures++; $display("FAIL reset_first_write got=%b/%0d/%0h exp=1/3/abcd", reg_write, write_reg, write_data); end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        advance();
    endtask

    task automatic test_single_req0();
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
        advance();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if ({reg_write, write_reg, write_data, grant_id} !== {1'b1, 5'd5, 32'h1234, 1'b0}) begin failures++; $display("FAIL single_write got=%b/%0d/%0h/%b exp=1/5/1234/0", reg_write, write_reg, write_data, grant_id); end
        advance();
        checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", reg_write); end
        checks++; if (write_reg !== 5'd5) begin failures++; $display("FAIL single_hold_addr got=%0d exp=5", write_reg); end
    endtask

    task automatic test_fairness();
        drive(1'b1, 5'd7, 32'hA0A0, 1'b1, 5'd9, 32'hB1B1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            logic exp1;
            exp1 = (i % 5 == 4);
            #2;
            checks++; if ({req0_ready, req1_ready} !== {!exp1, exp1}) begin failures++; $display("FAIL fair_ready[%0d] got=%b exp=%b", i, {req0_ready, req1_ready}, {!exp1, exp1}); end
            advance();
            checks++; if (starve_cnt !== (exp1 ? 4'd0 : 4'(i % 5 + 1))) begin failures++; $display("FAIL fair_cnt[%0d] got=%0d exp=%0d", i, starve_cnt, exp1 ? 0 : i % 5 + 1); end
            checks++; if ({reg_write, grant_id} !== {1'b1, exp1}) begin failures++; $display("FAIL fair_grant[%0d] got=%b/%b exp=1/%b", i, reg_write, grant_id, exp1); end
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        advance();
    endtask

    task automatic test_zero_reg();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        #2;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL zero_ready got=%b exp=01", {req0_ready, req1_ready}); end
        advance();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if ({reg_write, grant_id, write_reg, write_data} !== {1'b0, 1'b1, 5'd0, 32'hFFFFFFFF}) begin failures++; $display("FAIL zero_write got=%b/%b/%0d/%0h exp=0/1/0/ffffffff", reg_write, grant_id, write_reg, write_data); end
        advance();
    endtask

    task automatic test_hold();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33, 1'b0);
        advance(); advance();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL hold_ready[%0d] got=%b exp=00", i, {req0_ready, req1_ready}); end
            advance();
            checks++; if ({reg_write, starve_cnt} !== {1'b0, 4'd2}) begin failures++; $display("FAIL hold_state[%0d] got=%b/%0d exp=0/2", i, reg_write, starve_cnt); end
        end
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++; if (req1_ready !== (k == 2)) begin failures++; $display("FAIL hold_resume[%0d] got=%b exp=%b", k, req1_ready, k == 2); end
            advance();
            checks++; if (starve_cnt !== (k == 2 ? 4'd0 : 4'(3 + k))) begin failures++; $display("FAIL hold_resume_cnt[%0d] got=%0d exp=%0d", k, starve_cnt, k == 2 ? 0 : 3 + k); end
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        advance();
    endtask

    task automatic test_force_drop();
        drive(1'b1, 5'd10, 32'h1010, 1'b1, 5'd11, 32'h1111, 1'b0);
        for (int i = 0; i < LIMIT; i++) advance();
        checks++; if (starve_cnt !== 4'(LIMIT)) begin failures++; $display("FAIL force_cnt got=%0d exp=%0d", starve_cnt, LIMIT); end
        req1_valid = 1'b0;
        #2;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL force_drop_ready got=%b exp=10", {req0_ready, req1_ready}); end
        advance();
        checks++; if ({starve_cnt, grant_id, reg_write} !== {4'd0, 1'b0, 1'b1}) begin failures++; $display("FAIL force_drop_state got=%0d/%b/%b exp=0/0/1", starve_cnt, grant_id, reg_write); end
        req1_valid = 1'b1;
        #2;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL force_back_prio0 got=%b exp=10", {req0_ready, req1_ready}); end
        advance();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        advance();
    endtask

    task automatic test_reset_midcycle();
        drive(1'b1, 5'd6, 32'h6666, 1'b1, 5'd8, 32'h8888, 1'b0);
        advance(); advance();
        checks++; if ({reg_write, starve_cnt} !== {1'b1, 4'd2}) begin failures++; $display("FAIL mid_pre got=%b/%0d exp=1/2", reg_write, starve_cnt); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({reg_write, starve_cnt, write_reg, write_data} !== '0) begin failures++; $display("FAIL mid_async got=%b/%0d/%0d/%0h exp=0", reg_write, starve_cnt, write_reg, write_data); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL mid_ready got=%b exp=00", {req0_ready, req1_ready}); end
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        reset_n = 1'b1;
        advance();
        checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL mid_no_write got=%b exp=0", reg_write); end
    endtask

    task automatic test_random();
        logic p0 = 1'b0, p1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && ($urandom_range(0, 2) != 0)) begin
                p0 = 1'b1;
                req0_reg  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                req0_data = $urandom;
            end
            if (!p1 && ($urandom_range(0, 2) != 0)) begin
                p1 = 1'b1;
                req1_reg  = ($urandom_range(0, 3) == 0) ? req0_reg : 5'($urandom_range(0, 31));
                req1_data = $urandom;
            end
            req0_valid = p0;
            req1_valid = p1;
            hold = ($urandom_range(0, 7) == 0);
            #2;
            model_ready();
            checks++; if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, {req0_ready, req1_ready}, {e_r0, e_r1}); end
            if (e_r0) p0 = 1'b0;
            if (e_r1) p1 = 1'b0;
            advance();
            checks++; if ({reg_write, write_reg, write_data, grant_id} !== {m_rw, m_wreg, m_wdata, m_gid}) begin failures++; $display("FAIL rand_write[%0d] got=%b/%0d/%0h/%b exp=%b/%0d/%0h/%b", n, reg_write, write_reg, write_data, grant_id, m_rw, m_wreg, m_wdata, m_gid); end
            checks++; if (starve_cnt !== 4'(m_streak)) begin failures++; $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", n, starve_cnt, m_streak); end
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        advance();
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_fairness();
        test_zero_reg();
        test_hold();
        test_force_drop();
        test_reset_midcycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
